// File: rtl/wb_req_pkg.sv
// Shared types for the Wishbone request queue: the queued request payload
// and the states of the issue sequencer.
package wb_req_pkg;

   localparam int WB_W = 32;

   typedef struct packed {
      logic            we;
      logic [WB_W-1:0] adr;
      logic [WB_W-1:0] dat;
      logic [3:0]      sel;
   } wb_req_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT_START,
      ST_WAIT_DONE
   } wbq_state_t;

endpackage

// File: rtl/wb_req_fifo.sv
// Request FIFO: power-of-two depth, head visible combinationally, registered
// occupancy and ready so both can drive block outputs directly.
module wb_req_fifo
   import wb_req_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   push_i,
   input  wb_req_t                wdata_i,
   input  logic                   pop_i,
   output wb_req_t                rdata_o,
   output logic [$clog2(DEPTH):0] count_o,
   output logic                   ready_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          ready_q, ready_d;
   wb_req_t       mem_q [DEPTH];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_i, pop_i})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      // Ready follows the next occupancy so it is already low in the cycle the FIFO is full.
      ready_d = (count_d != CW'(DEPTH));
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ready_q  <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ready_q  <= ready_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_i) mem_q[wr_ptr_q] <= wdata_i;
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign count_o = count_q;
   assign ready_o = ready_q;

endmodule

// File: rtl/wishbone_request_queue.sv
// Queues CPU bus requests and issues them one at a time to the Wishbone
// manager CPU port, returning an in-order completion per request.
module wishbone_request_queue
   import wb_req_pkg::*;
#(
   parameter int DEPTH         = 4,
   parameter int START_TIMEOUT = 8
) (
   input  logic                   CLK,
   input  logic                   nRST,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic                   req_we,
   input  logic [WB_W-1:0]        req_adr,
   input  logic [WB_W-1:0]        req_dat,
   input  logic [3:0]             req_sel,
   output logic                   rsp_valid,
   output logic                   rsp_we,
   output logic [WB_W-1:0]        rsp_dat,
   output logic                   rsp_timeout,
   output logic [$clog2(DEPTH):0] count,
   output logic                   MGR_WRITE_O,
   output logic                   MGR_READ_O,
   output logic [WB_W-1:0]        MGR_ADR_O,
   output logic [WB_W-1:0]        MGR_DAT_O,
   output logic [3:0]             MGR_SEL_O,
   input  logic [WB_W-1:0]        MGR_DAT_I,
   input  logic                   MGR_BUSY_I
);

   localparam int                TW      = $clog2(START_TIMEOUT + 1);
   localparam logic [TW-1:0]     TO_LAST = TW'(START_TIMEOUT - 1);

   wbq_state_t      state_q, state_d;
   logic [TW-1:0]   tcnt_q, tcnt_d;
   logic            wr_q, wr_d, rd_q, rd_d;
   logic [WB_W-1:0] adr_q, adr_d, dat_q, dat_d;
   logic [3:0]      sel_q, sel_d;
   logic            rsp_valid_q, rsp_valid_d, rsp_we_q, rsp_we_d, rsp_to_q, rsp_to_d;
   logic [WB_W-1:0] rsp_dat_q, rsp_dat_d;

   logic    push, pop, fifo_ready;
   wb_req_t wdata, head;
   logic [$clog2(DEPTH):0] fifo_count;

   assign push  = req_valid & fifo_ready;
   assign wdata = '{we: req_we, adr: req_adr, dat: req_dat, sel: req_sel};

   wb_req_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk_i   (CLK),
      .rst_ni  (nRST),
      .push_i  (push),
      .wdata_i (wdata),
      .pop_i   (pop),
      .rdata_o (head),
      .count_o (fifo_count),
      .ready_o (fifo_ready)
   );

   always_comb begin
      state_d     = state_q;
      tcnt_d      = tcnt_q;
      wr_d        = 1'b0;
      rd_d        = 1'b0;
      adr_d       = adr_q;
      dat_d       = dat_q;
      sel_d       = sel_q;
      rsp_valid_d = 1'b0;
      rsp_we_d    = 1'b0;
      rsp_dat_d   = '0;
      rsp_to_d    = 1'b0;
      pop         = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (fifo_count != '0) begin
               adr_d   = head.adr;
               dat_d   = head.dat;
               sel_d   = head.sel;
               wr_d    = head.we;
               rd_d    = ~head.we;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            tcnt_d  = '0;
            state_d = ST_WAIT_START;
         end
         ST_WAIT_START: begin
            if (MGR_BUSY_I) begin
               state_d = ST_WAIT_DONE;
            end else if (tcnt_q == TO_LAST) begin
               rsp_valid_d = 1'b1;
               rsp_we_d    = head.we;
               rsp_to_d    = 1'b1;
               pop         = 1'b1;
               adr_d       = '0;
               dat_d       = '0;
               sel_d       = '0;
               state_d     = ST_IDLE;
            end else begin
               tcnt_d = tcnt_q + 1'b1;
            end
         end
         ST_WAIT_DONE: begin
            if (!MGR_BUSY_I) begin
               rsp_valid_d = 1'b1;
               rsp_we_d    = head.we;
               rsp_dat_d   = head.we ? '0 : MGR_DAT_I;
               pop         = 1'b1;
               adr_d       = '0;
               dat_d       = '0;
               sel_d       = '0;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q     <= ST_IDLE;
         tcnt_q      <= '0;
         wr_q        <= 1'b0;
         rd_q        <= 1'b0;
         adr_q       <= '0;
         dat_q       <= '0;
         sel_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_we_q    <= 1'b0;
         rsp_dat_q   <= '0;
         rsp_to_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         tcnt_q      <= tcnt_d;
         wr_q        <= wr_d;
         rd_q        <= rd_d;
         adr_q       <= adr_d;
         dat_q       <= dat_d;
         sel_q       <= sel_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_we_q    <= rsp_we_d;
         rsp_dat_q   <= rsp_dat_d;
         rsp_to_q    <= rsp_to_d;
      end
   end

   assign req_ready   = fifo_ready;
   assign count       = fifo_count;
   assign MGR_WRITE_O = wr_q;
   assign MGR_READ_O  = rd_q;
   assign MGR_ADR_O   = adr_q;
   assign MGR_DAT_O   = dat_q;
   assign MGR_SEL_O   = sel_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_we      = rsp_we_q;
   assign rsp_dat     = rsp_dat_q;
   assign rsp_timeout = rsp_to_q;

endmodule

// File: tb/tb_wishbone_request_queue.sv
// Directed bench for wishbone_request_queue with a small Wishbone manager model
// that answers strobes with a 4-cycle BUSY window and a word memory.
module tb_wishbone_request_queue;

   logic        CLK = 1'b0;
   logic        nRST;
   logic        req_valid, req_we;
   logic [31:0] req_adr, req_dat;
   logic [3:0]  req_sel;
   logic        req_ready, rsp_valid, rsp_we, rsp_timeout;
   logic [31:0] rsp_dat;
   logic [2:0]  count;
   logic        MGR_WRITE_O, MGR_READ_O;
   logic [31:0] MGR_ADR_O, MGR_DAT_O;
   logic [3:0]  MGR_SEL_O;
   logic [31:0] MGR_DAT_I;
   logic        MGR_BUSY_I;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int n_strobe = 0;
   logic mdl_never;
   logic [31:0] mmem [16];
   logic [1:0]  mcnt;

   logic        r_we [$];
   logic [31:0] r_dat [$];
   logic        r_to [$];
   int          r_cyc [$];

   always #5 CLK = ~CLK;

   wishbone_request_queue #(.DEPTH(4), .START_TIMEOUT(8)) dut (
      .CLK(CLK), .nRST(nRST),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_adr(req_adr), .req_dat(req_dat), .req_sel(req_sel),
      .rsp_valid(rsp_valid), .rsp_we(rsp_we), .rsp_dat(rsp_dat),
      .rsp_timeout(rsp_timeout), .count(count),
      .MGR_WRITE_O(MGR_WRITE_O), .MGR_READ_O(MGR_READ_O), .MGR_ADR_O(MGR_ADR_O),
      .MGR_DAT_O(MGR_DAT_O), .MGR_SEL_O(MGR_SEL_O),
      .MGR_DAT_I(MGR_DAT_I), .MGR_BUSY_I(MGR_BUSY_I)
   );

   // Manager model: BUSY high for the 4 cycles following a strobe.
   always @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         MGR_BUSY_I <= 1'b0;
         MGR_DAT_I  <= '0;
         mcnt       <= '0;
      end else if ((MGR_WRITE_O || MGR_READ_O) && !mdl_never) begin
         MGR_BUSY_I <= 1'b1;
         mcnt       <= 2'd3;
         if (MGR_WRITE_O) mmem[MGR_ADR_O[5:2]] <= MGR_DAT_O;
         else             MGR_DAT_I <= mmem[MGR_ADR_O[5:2]];
      end else if (MGR_BUSY_I) begin
         if (mcnt == 2'd0) MGR_BUSY_I <= 1'b0;
         else              mcnt <= mcnt - 2'd1;
      end
   end

   always @(posedge CLK) begin
      cyc <= cyc + 1;
      if (rsp_valid) begin
         r_we.push_back(rsp_we);
         r_dat.push_back(rsp_dat);
         r_to.push_back(rsp_timeout);
         r_cyc.push_back(cyc);
      end
      if (MGR_WRITE_O || MGR_READ_O) n_strobe <= n_strobe + 1;
   end

   function automatic logic [31:0] adr_of(input int i);
      return 32'h3100_0000 + 32'(i * 4);
   endfunction

   task automatic push(input logic we, input logic [31:0] adr, input logic [31:0] dat, output int acc);
      req_valid = 1'b1; req_we = we; req_adr = adr; req_dat = dat; req_sel = 4'hF;
      acc = -1;
      for (int k = 0; k < 200; k++) begin
         if (req_ready) begin
            acc = cyc;
            @(posedge CLK); #1;
            break;
         end
         @(posedge CLK); #1;
      end
      req_valid = 1'b0;
      if (acc < 0) begin
         n_cmp++; n_err++;
         $display("FAIL push_accept: request at %h never accepted", adr);
      end
   endtask

   task automatic wait_rsp(input int n, input string tag);
      int k = 0;
      while (r_we.size() < n && k < 200) begin
         @(posedge CLK); #1;
         k++;
      end
      n_cmp++;
      if (r_we.size() < n) begin
         n_err++;
         $display("FAIL %s: responses seen %0d, required %0d", tag, r_we.size(), n);
      end
   endtask

   task automatic get_rsp(output logic we, output logic [31:0] dat, output logic to, output int c);
      if (r_we.size() > 0) begin
         we = r_we.pop_front(); dat = r_dat.pop_front();
         to = r_to.pop_front(); c = r_cyc.pop_front();
      end else begin
         we = 1'bx; dat = 'x; to = 1'bx; c = -1;
      end
   endtask

   task automatic test_reset();
      repeat (3) @(posedge CLK);
      #1;
      n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b want 1", req_ready); end
      n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL rst_count: got %0d want 0", count); end
      n_cmp++; if ({MGR_WRITE_O, MGR_READ_O, MGR_ADR_O, MGR_DAT_O, MGR_SEL_O} !== 70'd0) begin
         n_err++; $display("FAIL rst_mgr: wr=%b rd=%b adr=%h dat=%h sel=%h want all 0", MGR_WRITE_O, MGR_READ_O, MGR_ADR_O, MGR_DAT_O, MGR_SEL_O);
      end
      n_cmp++; if ({rsp_valid, rsp_we, rsp_timeout, rsp_dat} !== 35'd0) begin
         n_err++; $display("FAIL rst_rsp: v=%b we=%b to=%b dat=%h want all 0", rsp_valid, rsp_we, rsp_timeout, rsp_dat);
      end
      nRST = 1'b1;
      @(posedge CLK); #1;
      n_cmp++; if (req_ready !== 1'b1 || count !== 3'd0) begin
         n_err++; $display("FAIL rst_release: ready=%b count=%0d want 1/0", req_ready, count);
      end
   endtask

   task automatic test_single_write();
      int acc, t_iss, c;
      logic we; logic [31:0] d; logic to;
      push(1'b1, adr_of(0), 32'd12, acc);
      n_cmp++; if (count !== 3'd1) begin n_err++; $display("FAIL wr_count: got %0d want 1", count); end
      n_cmp++; if (MGR_WRITE_O !== 1'b0) begin n_err++; $display("FAIL wr_early: strobe %b want 0", MGR_WRITE_O); end
      @(posedge CLK); #1;
      t_iss = cyc;
      n_cmp++; if (MGR_WRITE_O !== 1'b1 || MGR_READ_O !== 1'b0) begin
         n_err++; $display("FAIL wr_strobe: wr=%b rd=%b want 1/0", MGR_WRITE_O, MGR_READ_O);
      end
      n_cmp++; if (MGR_ADR_O !== 32'h3100_0000 || MGR_DAT_O !== 32'd12 || MGR_SEL_O !== 4'hF) begin
         n_err++; $display("FAIL wr_payload: adr=%h dat=%h sel=%h want 31000000/0000000c/f", MGR_ADR_O, MGR_DAT_O, MGR_SEL_O);
      end
      @(posedge CLK); #1;
      n_cmp++; if (MGR_WRITE_O !== 1'b0 || MGR_ADR_O !== 32'h3100_0000 || MGR_DAT_O !== 32'd12) begin
         n_err++; $display("FAIL wr_hold: wr=%b adr=%h dat=%h want 0/31000000/0000000c", MGR_WRITE_O, MGR_ADR_O, MGR_DAT_O);
      end
      wait_rsp(1, "wr_rsp_wait");
      get_rsp(we, d, to, c);
      n_cmp++; if (we !== 1'b1 || d !== 32'd0 || to !== 1'b0) begin
         n_err++; $display("FAIL wr_rsp: we=%b dat=%h to=%b want 1/00000000/0", we, d, to);
      end
      n_cmp++; if (c !== t_iss + 6) begin n_err++; $display("FAIL wr_latency: rsp cycle %0d want %0d", c, t_iss + 6); end
      n_cmp++; if (rsp_valid !== 1'b0 || MGR_ADR_O !== 32'd0) begin
         n_err++; $display("FAIL wr_after: rsp_valid=%b adr=%h want 0/00000000", rsp_valid, MGR_ADR_O);
      end
   endtask

   task automatic test_read();
      int acc, c;
      logic we; logic [31:0] d; logic to;
      push(1'b0, adr_of(0), 32'd0, acc);
      @(posedge CLK); #1;
      n_cmp++; if (MGR_READ_O !== 1'b1 || MGR_WRITE_O !== 1'b0) begin
         n_err++; $display("FAIL rd_strobe: rd=%b wr=%b want 1/0", MGR_READ_O, MGR_WRITE_O);
      end
      wait_rsp(1, "rd_rsp_wait");
      get_rsp(we, d, to, c);
      n_cmp++; if (we !== 1'b0 || d !== 32'h0000_000C || to !== 1'b0) begin
         n_err++; $display("FAIL rd_rsp: we=%b dat=%h to=%b want 0/0000000c/0", we, d, to);
      end
   endtask

   task automatic test_back_to_back();
      int acc, acc5, c;
      logic we; logic [31:0] d; logic to;
      logic        exp_we [5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      logic [31:0] exp_dat [5] = '{32'h0, 32'h0, 32'h11, 32'h22, 32'hC};
      push(1'b1, adr_of(1), 32'h11, acc);
      push(1'b1, adr_of(2), 32'h22, acc);
      push(1'b0, adr_of(1), 32'h0, acc);
      push(1'b0, adr_of(2), 32'h0, acc);
      n_cmp++; if (req_ready !== 1'b0 || count !== 3'd4) begin
         n_err++; $display("FAIL b2b_full: ready=%b count=%0d want 0/4", req_ready, count);
      end
      push(1'b0, adr_of(0), 32'h0, acc5);
      n_cmp++; if (r_cyc.size() == 0 || acc5 !== r_cyc[0]) begin
         n_err++; $display("FAIL b2b_fifth: accepted in cycle %0d want first completion cycle %0d", acc5, (r_cyc.size() > 0) ? r_cyc[0] : -1);
      end
      wait_rsp(5, "b2b_rsp_wait");
      for (int i = 0; i < 5; i++) begin
         get_rsp(we, d, to, c);
         n_cmp++; if (we !== exp_we[i] || d !== exp_dat[i] || to !== 1'b0) begin
            n_err++; $display("FAIL b2b_order[%0d]: we=%b dat=%h to=%b want %b/%h/0", i, we, d, to, exp_we[i], exp_dat[i]);
         end
      end
   endtask

   task automatic test_push_pop_same();
      int acc, c, k;
      logic prev, fall;
      logic we; logic [31:0] d; logic to;
      logic        exp_we [4]  = '{1'b0, 1'b0, 1'b1, 1'b0};
      logic [31:0] exp_dat [4] = '{32'h11, 32'h22, 32'h0, 32'h33};
      push(1'b0, adr_of(1), 32'h0, acc);
      push(1'b0, adr_of(2), 32'h0, acc);
      push(1'b1, adr_of(3), 32'h33, acc);
      prev = MGR_BUSY_I; k = 0; fall = 1'b0;
      while (!fall && k < 100) begin
         @(posedge CLK); #1;
         k++;
         fall = prev && !MGR_BUSY_I;
         prev = MGR_BUSY_I;
      end
      n_cmp++; if (count !== 3'd3 || req_ready !== 1'b1) begin
         n_err++; $display("FAIL pp_before: count=%0d ready=%b want 3/1", count, req_ready);
      end
      req_valid = 1'b1; req_we = 1'b0; req_adr = adr_of(3); req_dat = 32'h0; req_sel = 4'hF;
      @(posedge CLK); #1;
      req_valid = 1'b0;
      n_cmp++; if (count !== 3'd3 || rsp_valid !== 1'b1) begin
         n_err++; $display("FAIL pp_same: count=%0d rsp_valid=%b want 3/1", count, rsp_valid);
      end
      wait_rsp(4, "pp_rsp_wait");
      for (int i = 0; i < 4; i++) begin
         get_rsp(we, d, to, c);
         n_cmp++; if (we !== exp_we[i] || d !== exp_dat[i] || to !== 1'b0) begin
            n_err++; $display("FAIL pp_order[%0d]: we=%b dat=%h to=%b want %b/%h/0", i, we, d, to, exp_we[i], exp_dat[i]);
         end
      end
   endtask

   task automatic test_timeout();
      int acc, t_iss, c, k;
      logic we; logic [31:0] d; logic to;
      mdl_never = 1'b1;
      push(1'b0, adr_of(5), 32'h0, acc);
      push(1'b1, adr_of(6), 32'h66, acc);
      k = 0;
      while (!MGR_READ_O && k < 50) begin
         @(posedge CLK); #1;
         k++;
      end
      t_iss = cyc;
      wait_rsp(1, "to_rsp_wait");
      mdl_never = 1'b0;
      get_rsp(we, d, to, c);
      n_cmp++; if (to !== 1'b1 || we !== 1'b0 || d !== 32'd0) begin
         n_err++; $display("FAIL to_rsp: to=%b we=%b dat=%h want 1/0/00000000", to, we, d);
      end
      n_cmp++; if (c !== t_iss + 9) begin n_err++; $display("FAIL to_latency: rsp cycle %0d want %0d", c, t_iss + 9); end
      n_cmp++; if (MGR_WRITE_O !== 1'b1 || MGR_ADR_O !== adr_of(6)) begin
         n_err++; $display("FAIL to_next_issue: wr=%b adr=%h want 1/%h", MGR_WRITE_O, MGR_ADR_O, adr_of(6));
      end
      wait_rsp(1, "to_next_wait");
      get_rsp(we, d, to, c);
      n_cmp++; if (to !== 1'b0 || we !== 1'b1 || d !== 32'd0) begin
         n_err++; $display("FAIL to_next_rsp: to=%b we=%b dat=%h want 0/1/00000000", to, we, d);
      end
   endtask

   task automatic test_reset_mid();
      int acc, k, hi, s0;
      push(1'b1, adr_of(8), 32'h88, acc);
      push(1'b1, adr_of(9), 32'h99, acc);
      push(1'b1, adr_of(10), 32'hAA, acc);
      k = 0; hi = 0;
      while (hi < 2 && k < 50) begin
         @(posedge CLK); #1;
         k++;
         hi = MGR_BUSY_I ? hi + 1 : 0;
      end
      n_cmp++; if (MGR_ADR_O !== adr_of(8) || count !== 3'd3) begin
         n_err++; $display("FAIL mid_pre: adr=%h count=%0d want %h/3", MGR_ADR_O, count, adr_of(8));
      end
      #3 nRST = 1'b0;
      #1;
      n_cmp++; if ({MGR_WRITE_O, MGR_READ_O, MGR_ADR_O, MGR_DAT_O, MGR_SEL_O} !== 70'd0) begin
         n_err++; $display("FAIL mid_mgr: wr=%b rd=%b adr=%h dat=%h sel=%h want all 0", MGR_WRITE_O, MGR_READ_O, MGR_ADR_O, MGR_DAT_O, MGR_SEL_O);
      end
      n_cmp++; if (count !== 3'd0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
         n_err++; $display("FAIL mid_ctrl: count=%0d ready=%b rsp_valid=%b want 0/1/0", count, req_ready, rsp_valid);
      end
      @(posedge CLK); @(posedge CLK); #1;
      nRST = 1'b1;
      s0 = n_strobe;
      repeat (20) @(posedge CLK);
      #1;
      n_cmp++; if (r_we.size() != 0 || n_strobe != s0 || count !== 3'd0) begin
         n_err++; $display("FAIL mid_after: rsp=%0d new strobes=%0d count=%0d want 0/0/0", r_we.size(), n_strobe - s0, count);
      end
   endtask

   initial begin
      nRST = 1'b0; req_valid = 1'b0; req_we = 1'b0;
      req_adr = '0; req_dat = '0; req_sel = '0; mdl_never = 1'b0;
      test_reset();
      test_single_write();
      test_read();
      test_back_to_back();
      test_push_pop_same();
      test_timeout();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
